// File: rtl/cache_ctrl_if.sv
// Signal bundle between the cache controller and its neighbours: CPU data port,
// cache lookup/update port and external memory bus.
interface cache_ctrl_if #(
   parameter int XLEN = 32
);
   logic            cpu_req;
   logic            cpu_we;
   logic [XLEN-1:0] cpu_addr;
   logic [XLEN-1:0] cpu_wdata;
   logic            cpu_ready;
   logic            cpu_done;
   logic            cpu_err;
   logic [XLEN-1:0] cpu_rdata;

   logic [XLEN-1:0] cache_addr;
   logic            cache_hit;
   logic [XLEN-1:0] cache_rdata;
   logic            cache_update;
   logic [XLEN-1:0] cache_update_addr;
   logic [XLEN-1:0] cache_update_data;

   logic            mem_req;
   logic            mem_we;
   logic [XLEN-1:0] mem_addr;
   logic [XLEN-1:0] mem_wdata;
   logic            mem_ack;
   logic [XLEN-1:0] mem_rdata;

   // The controller is the slave of the CPU port; the environment (CPU, cache, memory) is the master.
   modport slave (
      input  cpu_req, cpu_we, cpu_addr, cpu_wdata, cache_hit, cache_rdata, mem_ack, mem_rdata,
      output cpu_ready, cpu_done, cpu_err, cpu_rdata, cache_addr, cache_update,
             cache_update_addr, cache_update_data, mem_req, mem_we, mem_addr, mem_wdata
   );

   modport master (
      output cpu_req, cpu_we, cpu_addr, cpu_wdata, cache_hit, cache_rdata, mem_ack, mem_rdata,
      input  cpu_ready, cpu_done, cpu_err, cpu_rdata, cache_addr, cache_update,
             cache_update_addr, cache_update_data, mem_req, mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/cache_ctrl.sv
// Single-request cache sequencer: lookup, miss fill, write-through store and memory
// timeout, between the CPU data port and the external memory bus.
module cache_ctrl #(
   parameter int XLEN    = 32,
   parameter int TIMEOUT = 255
) (
   input logic         clk,
   input logic         rst_n,
   cache_ctrl_if.slave bus
);
   localparam int            CW       = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      IDLE,
      LOOKUP,
      MEM_RD,
      MEM_WR,
      FILL,
      ERR
   } state_t;

   state_t          state;
   state_t          state_next;
   logic [CW-1:0]   cnt;
   logic [XLEN-1:0] addr_q;
   logic [XLEN-1:0] wdata_q;
   logic [XLEN-1:0] fill_q;
   logic            we_q;
   logic            in_mem;

   logic            done;
   logic            err;
   logic [XLEN-1:0] rdata;
   logic            update;
   logic            mreq;
   logic            mwe;

   assign in_mem = (state == MEM_RD) || (state == MEM_WR);

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (!rst_n) begin
         state   <= IDLE;
         cnt     <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         fill_q  <= '0;
         we_q    <= 1'b0;
      end else begin
         state <= state_next;
         if (state == IDLE && bus.cpu_req) begin
            addr_q  <= bus.cpu_addr;
            we_q    <= bus.cpu_we;
            wdata_q <= bus.cpu_wdata;
         end
         // Counter runs only while waiting on memory, so it is zero on every entry.
         cnt <= in_mem ? cnt + 1'b1 : '0;
         if (in_mem && bus.mem_ack)
            fill_q <= (state == MEM_RD) ? bus.mem_rdata : wdata_q;
      end
   end

   always_comb begin
      // NOTE: every output of this block gets a default first, so no path leaves one unassigned (no latch).
      state_next = state;
      done       = 1'b0;
      err        = 1'b0;
      rdata      = '0;
      update     = 1'b0;
      mreq       = 1'b0;
      mwe        = 1'b0;
      case (state)
         IDLE:   if (bus.cpu_req) state_next = LOOKUP;
         LOOKUP: begin
            if (we_q) begin
               state_next = MEM_WR;
            end else if (bus.cache_hit) begin
               done       = 1'b1;
               rdata      = bus.cache_rdata;
               state_next = IDLE;
            end else begin
               state_next = MEM_RD;
            end
         end
         MEM_RD, MEM_WR: begin
            mreq = 1'b1;
            mwe  = (state == MEM_WR);
            // An ack in the expiry cycle still completes the request normally.
            if (bus.mem_ack)           state_next = FILL;
            else if (cnt == CNT_LAST)  state_next = ERR;
         end
         FILL: begin
            update     = 1'b1;
            done       = 1'b1;
            rdata      = fill_q;
            state_next = IDLE;
         end
         ERR: begin
            done       = 1'b1;
            err        = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Reset is synchronous, so strobes are masked while rst_n is low to abort a request in that very cycle.
   assign bus.cpu_ready         = (state == IDLE) || !rst_n;
   assign bus.cpu_done          = done && rst_n;
   assign bus.cpu_err           = err && rst_n;
   assign bus.cpu_rdata         = rdata;
   assign bus.cache_addr        = addr_q;
   assign bus.cache_update      = update && rst_n;
   assign bus.cache_update_addr = addr_q;
   assign bus.cache_update_data = fill_q;
   assign bus.mem_req           = mreq && rst_n;
   assign bus.mem_we            = mwe && rst_n;
   assign bus.mem_addr          = addr_q;
   assign bus.mem_wdata         = wdata_q;
endmodule
